// File: rtl/pll_rst_pkg.sv
// ---------------------------------------------------------------------------
// pll_rst_pkg
//
// Shared definitions for the PLL lock reset sequencer and its neighbours.
//   - 2-bit FSM state encodings (kept as plain constants so the debug state
//     bus keeps the same numeric values in every tool and on the PMOD header)
//   - default parameter values
//   - cnt_width(): counter width helper, never narrower than one bit
// ---------------------------------------------------------------------------
package pll_rst_pkg;

  // FSM state encodings, also driven out on the debug state port.
  localparam logic [1:0] ST_HOLD      = 2'd0;
  localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
  localparam logic [1:0] ST_STABLE    = 2'd2;
  localparam logic [1:0] ST_RUN       = 2'd3;

  // Default parameter values.
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_HOLD_CYCLES = 16;
  localparam int DEF_LOCK_CYCLES = 1024;
  localparam int DEF_LOSS_W      = 8;

  // Width of a counter that must hold the values 0 .. n-1.
  // $clog2(1) is 0, so single-count counters still get one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : pll_rst_pkg

// File: rtl/sync_ff.sv
// ---------------------------------------------------------------------------
// sync_ff
//
// N-stage flip-flop synchronizer for signals asynchronous to clk. Every stage
// resets to 0 asynchronously. Reused for other asynchronous board inputs, so
// the data width is a parameter.
//
// Parameters:
//   STAGES  number of flops in the chain (2 or more)
//   WIDTH   number of independent single-bit signals synchronized in parallel
//
// Ports:
//   clk   destination clock
//   rst   asynchronous active-high reset, clears every stage
//   d     asynchronous input(s)
//   q     synchronized output(s), STAGES clk edges behind d
// ---------------------------------------------------------------------------
module sync_ff #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // chain[0] is the metastability-catching flop, chain[STAGES-1] drives q.
  logic [STAGES-1:0][WIDTH-1:0] chain;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the value its neighbour held before the edge; blocking
  // assignments here would collapse the chain into a single flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule : sync_ff

// File: rtl/pll_lock_reset.sv
// ---------------------------------------------------------------------------
// pll_lock_reset
//
// Reset sequencer in front of the free-running counter/LED/PMOD stage.
// The raw PLL lock flag is synchronized, then qualified by:
//   HOLD       reset held for at least HOLD_CYCLES cycles, lock ignored
//   WAIT_LOCK  waiting for the synchronized lock flag
//   STABLE     lock must stay high for LOCK_CYCLES consecutive cycles
//   RUN        downstream reset released
// Losing lock in RUN goes straight back to HOLD (so a full hold period is
// always served), pulses lock_lost for one cycle and bumps a saturating
// loss counter that is brought out to the PMOD debug header.
//
// Parameters:
//   SYNC_STAGES  depth of the pll_locked synchronizer (2 or more)
//   HOLD_CYCLES  minimum cycles rst_out stays high after entering HOLD
//   LOCK_CYCLES  consecutive locked cycles required before release
//   LOSS_W       width of loss_count
//
// Ports:
//   clk         PLL clk0, the counter-domain clock
//   rst         asynchronous active-high reset
//   pll_locked  raw PLL lock flag, asynchronous to clk
//   rst_out     registered active-high reset for downstream logic
//   ready       registered, high exactly while the FSM is in RUN
//   lock_lost   one-cycle pulse on loss of lock while in RUN
//   loss_count  saturating count of lock-loss events
//   state       current FSM state (debug)
// ---------------------------------------------------------------------------
module pll_lock_reset
  import pll_rst_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
  parameter int LOSS_W      = DEF_LOSS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pll_locked,
  output logic              rst_out,
  output logic              ready,
  output logic              lock_lost,
  output logic [LOSS_W-1:0] loss_count,
  output logic [1:0]        state
);

  localparam int HOLD_W = cnt_width(HOLD_CYCLES);
  localparam int LOCK_W = cnt_width(LOCK_CYCLES);

  // Terminal counts: the state advances on the cycle the counter reads these.
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [LOSS_W-1:0] LOSS_MAX  = '1;

  logic              locked_s;
  logic [HOLD_W-1:0] hold_cnt;
  logic [LOCK_W-1:0] lock_cnt;

  logic [1:0]        state_nxt;
  logic [HOLD_W-1:0] hold_nxt;
  logic [LOCK_W-1:0] lock_nxt;
  logic              loss_evt;

  // -------------------------------------------------------------------------
  // Lock synchronizer: the FSM only ever looks at locked_s.
  // -------------------------------------------------------------------------
  sync_ff #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (1)
  ) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every signal written here gets a default before the case; any path
  // that left one unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    lock_nxt  = lock_cnt;
    loss_evt  = 1'b0;

    case (state)
      ST_HOLD: begin
        // Lock status is deliberately ignored until the hold time expires.
        if (hold_cnt == HOLD_LAST) begin
          state_nxt = ST_WAIT_LOCK;
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end

      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_nxt = ST_STABLE;
          lock_nxt  = '0;
        end
      end

      ST_STABLE: begin
        // A drop here is a failed qualification, not a loss event: restart
        // the stability window without touching loss_count.
        if (!locked_s) begin
          state_nxt = ST_WAIT_LOCK;
          lock_nxt  = '0;
        end else if (lock_cnt == LOCK_LAST) begin
          state_nxt = ST_RUN;
        end else begin
          lock_nxt = lock_cnt + 1'b1;
        end
      end

      ST_RUN: begin
        if (!locked_s) begin
          state_nxt = ST_HOLD;
          hold_nxt  = '0;
          loss_evt  = 1'b1;
        end
      end

      default: begin
        state_nxt = ST_HOLD;
        hold_nxt  = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State and counters
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_HOLD;
      hold_cnt <= '0;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      lock_cnt <= lock_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Registered outputs, decoded from the next state so they move on the same
  // edge as the state register and never glitch downstream.
  // -------------------------------------------------------------------------
  // NOTE: rst_out resets to 1, not 0: downstream logic must sit in reset
  // for as long as this block itself is being reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_out    <= 1'b1;
      ready      <= 1'b0;
      lock_lost  <= 1'b0;
      loss_count <= '0;
    end else begin
      rst_out   <= (state_nxt != ST_RUN);
      ready     <= (state_nxt == ST_RUN);
      lock_lost <= loss_evt;
      // Saturate so the debug header never shows a wrapped, misleading count.
      if (loss_evt && (loss_count != LOSS_MAX)) begin
        loss_count <= loss_count + 1'b1;
      end
    end
  end

endmodule : pll_lock_reset

// File: tb/tb_pll_lock_reset.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_reset
//
// Scoreboard bench for pll_lock_reset (SYNC_STAGES=2, HOLD_CYCLES=4,
// LOCK_CYCLES=8, LOSS_W=2). Stimulus tasks push the hand-computed output
// changes they expect, stamped with the clock edge on which they must occur.
// An independent monitor samples the outputs on every falling edge and, each
// time any output differs from the previous sample, pops the next expected
// entry and compares edge number and output values.
// ---------------------------------------------------------------------------
module tb_pll_lock_reset;

  localparam logic [1:0] S_HOLD   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_STABLE = 2'd2;
  localparam logic [1:0] S_RUN    = 2'd3;

  logic       clk        = 1'b0;
  logic       rst        = 1'b1;
  logic       pll_locked = 1'b0;
  logic       rst_out;
  logic       ready;
  logic       lock_lost;
  logic [1:0] loss_count;
  logic [1:0] state;

  typedef struct packed {
    logic [1:0] st;
    logic       ro;
    logic       rdy;
    logic       ll;
    logic [1:0] lc;
  } out_t;

  typedef struct packed {
    int   cyc;
    out_t o;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  base     = 0;
  bit  mon_en   = 1'b0;

  pll_lock_reset #(
    .SYNC_STAGES (2),
    .HOLD_CYCLES (4),
    .LOCK_CYCLES (8),
    .LOSS_W      (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .rst_out    (rst_out),
    .ready      (ready),
    .lock_lost  (lock_lost),
    .loss_count (loss_count),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Edge counter: at a falling edge, cyc equals the number of rising edges.
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int at, input logic [1:0] st, input logic ro,
                           input logic rdy, input logic ll, input logic [1:0] lc);
    exp_q.push_back(ev_t'{at, out_t'{st, ro, rdy, ll, lc}});
  endtask

  // Returns at falling edge + 1 time unit once cyc has reached c.
  task automatic at_cycle(input int c);
    while (cyc < c) @(negedge clk);
    #1;
  endtask

  // Wait (bounded) for all expected events, then idle a few cycles so any
  // stray extra output change is caught by the monitor.
  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    #1;
    check(name, exp_q.size(), 0);
  endtask

  // Assert rst between clock edges, check the reset values immediately
  // (no clock edge in between), hold a few cycles, then release.
  task automatic apply_reset(input logic lock_level);
    @(negedge clk);
    #1;
    mon_en     = 1'b0;
    rst        = 1'b1;
    pll_locked = lock_level;
    #1;
    check("rst_state",      state,      S_HOLD);
    check("rst_rst_out",    rst_out,    1);
    check("rst_ready",      ready,      0);
    check("rst_lock_lost",  lock_lost,  0);
    check("rst_loss_count", loss_count, 0);
    repeat (3) @(negedge clk);
    #1;
    rst    = 1'b0;
    base   = cyc;
    mon_en = 1'b1;
  endtask

  // One-cycle lock drop while in RUN; n is the expected loss_count after it.
  task automatic lose_lock(input logic [1:0] n);
    int c;
    c = cyc;
    expect_ev(c + 3,  S_HOLD,   1'b1, 1'b0, 1'b1, n);
    expect_ev(c + 4,  S_HOLD,   1'b1, 1'b0, 1'b0, n);
    expect_ev(c + 7,  S_WAIT,   1'b1, 1'b0, 1'b0, n);
    expect_ev(c + 8,  S_STABLE, 1'b1, 1'b0, 1'b0, n);
    expect_ev(c + 16, S_RUN,    1'b0, 1'b1, 1'b0, n);
    pll_locked = 1'b0;
    at_cycle(c + 1);
    pll_locked = 1'b1;
    drain("loss_drain");
  endtask

  // Monitor: compares each output change against the scoreboard.
  initial begin
    out_t prev_o;
    out_t cur_o;
    ev_t  e;
    prev_o = '0;
    forever begin
      @(negedge clk);
      cur_o = out_t'{state, rst_out, ready, lock_lost, loss_count};
      if (mon_en && cur_o != prev_o) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event @%0d: st=%0d ro=%0b rdy=%0b ll=%0b lc=%0d",
                   cyc, cur_o.st, cur_o.ro, cur_o.rdy, cur_o.ll, cur_o.lc);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.o != cur_o) begin
            n_fail++;
            $display("FAIL event: got @%0d st=%0d ro=%0b rdy=%0b ll=%0b lc=%0d, expected @%0d st=%0d ro=%0b rdy=%0b ll=%0b lc=%0d",
                     cyc, cur_o.st, cur_o.ro, cur_o.rdy, cur_o.ll, cur_o.lc,
                     e.cyc, e.o.st, e.o.ro, e.o.rdy, e.o.ll, e.o.lc);
          end
        end
      end
      prev_o = cur_o;
    end
  end

  // Stimulus
  initial begin
    // 1. Release timing with lock already high: RUN on edge 4+1+8 = 13.
    apply_reset(1'b1);
    expect_ev(base + 4,  S_WAIT,   1'b1, 1'b0, 1'b0, 2'd0);
    expect_ev(base + 5,  S_STABLE, 1'b1, 1'b0, 1'b0, 2'd0);
    expect_ev(base + 13, S_RUN,    1'b0, 1'b1, 1'b0, 2'd0);
    drain("release_drain");

    // 2. Late lock: pll_locked rises after edge 20, release 11 edges later.
    apply_reset(1'b0);
    expect_ev(base + 4,  S_WAIT,   1'b1, 1'b0, 1'b0, 2'd0);
    expect_ev(base + 23, S_STABLE, 1'b1, 1'b0, 1'b0, 2'd0);
    expect_ev(base + 31, S_RUN,    1'b0, 1'b1, 1'b0, 2'd0);
    at_cycle(base + 20);
    pll_locked = 1'b1;
    drain("late_lock_drain");

    // 3. Glitch seen by STABLE while lock_cnt==5 (edge 11): back to
    //    WAIT_LOCK, no loss counted, fresh 8-cycle window.
    apply_reset(1'b1);
    expect_ev(base + 4,  S_WAIT,   1'b1, 1'b0, 1'b0, 2'd0);
    expect_ev(base + 5,  S_STABLE, 1'b1, 1'b0, 1'b0, 2'd0);
    expect_ev(base + 11, S_WAIT,   1'b1, 1'b0, 1'b0, 2'd0);
    expect_ev(base + 12, S_STABLE, 1'b1, 1'b0, 1'b0, 2'd0);
    expect_ev(base + 20, S_RUN,    1'b0, 1'b1, 1'b0, 2'd0);
    at_cycle(base + 8);
    pll_locked = 1'b0;
    at_cycle(base + 9);
    pll_locked = 1'b1;
    drain("glitch_drain");

    // 4/5. Losses in RUN: full HOLD each time, count saturates 1,2,3,3.
    lose_lock(2'd1);
    lose_lock(2'd2);
    lose_lock(2'd3);
    lose_lock(2'd3);

    // 6. Async reset while in RUN clears everything without a clock edge.
    @(negedge clk);
    #1;
    check("pre_reset_ready",      ready,      1);
    check("pre_reset_loss_count", loss_count, 3);
    apply_reset(1'b1);

    // 7. Lock drop seen on the final STABLE cycle (lock_cnt==7, edge 13):
    //    no release, back to WAIT_LOCK, release 9 edges after re-entry.
    expect_ev(base + 4,  S_WAIT,   1'b1, 1'b0, 1'b0, 2'd0);
    expect_ev(base + 5,  S_STABLE, 1'b1, 1'b0, 1'b0, 2'd0);
    expect_ev(base + 13, S_WAIT,   1'b1, 1'b0, 1'b0, 2'd0);
    expect_ev(base + 14, S_STABLE, 1'b1, 1'b0, 1'b0, 2'd0);
    expect_ev(base + 22, S_RUN,    1'b0, 1'b1, 1'b0, 2'd0);
    at_cycle(base + 10);
    pll_locked = 1'b0;
    at_cycle(base + 11);
    pll_locked = 1'b1;
    drain("final_stable_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pll_lock_reset
